// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer and owner of HI/LO.
//
// Accepts MULT/MULTU/DIV/DIVU (aluop codes 6'b0110xx), iterates one bit per
// cycle for WIDTH cycles, then applies signs and writes HI/LO in a single
// fix-up cycle. Stalls MFHI/MFLO while an operation is in flight.
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_start    request strobe, sampled only in IDLE
//   i_op       aluop: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//   i_a, i_b   rs / rt operands
//   i_mf_req   MFHI/MFLO in execute
//   i_mf_sel   1 = HI, 0 = LO
//   o_mf_data  combinational HI or LO
//   o_stall    combinational i_mf_req & busy
//   o_busy     registered, operation in flight
//   o_done     registered one-cycle pulse when HI/LO are written
//   o_hi, o_lo architectural HI/LO
//
// state  | meaning
// S_IDLE | waiting for a legal start
// S_CALC | one shift-add / restoring-subtract step per cycle, WIDTH cycles
// S_FIX  | apply signs, write HI/LO, pulse done

module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [5:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mf_req,
  input  logic             i_mf_sel,
  output logic [WIDTH-1:0] o_mf_data,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic               w_load;

  // Operation context latched at start.
  logic               r_is_div;
  logic               r_neg_lo;   // negate product (mult) or quotient (div)
  logic               r_neg_hi;   // remainder takes the dividend's sign
  logic               r_dbz;
  logic [WIDTH-1:0]   r_a_raw;    // original dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude or divisor magnitude

  // Decode of the incoming request.
  logic               w_legal;
  logic               w_div_op;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_legal  = (i_op[5:2] == 4'b0110);
  assign w_div_op = i_op[1];
  assign w_sa     = ~i_op[0] & i_a[WIDTH-1];
  assign w_sb     = ~i_op[0] & i_b[WIDTH-1];
  assign w_a_mag  = w_sa ? -i_a : i_a;
  assign w_b_mag  = w_sb ? -i_b : i_b;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // The multiplier's LSB selects the add, then everything shifts right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend bits / quotient bits}.
  // The trial remainder is one bit wider than the divisor; when it is >= the
  // divisor the difference always fits back into WIDTH bits.
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_nxt;

  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_opnd});
  assign w_diff    = w_trial[WIDTH-1:0] - r_opnd;
  assign w_div_nxt = {(w_ge ? w_diff : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  // Sign fix-up.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_q_fix    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r_fix    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_legal) begin
          w_state_nxt = S_CALC;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
          w_acc_nxt   = {{WIDTH{1'b0}}, (w_div_op ? w_a_mag : w_b_mag)};
        end
      end
      S_CALC: begin
        w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
        if (r_count == LAST_CNT) begin
          w_state_nxt = S_FIX;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        if (!r_is_div) begin
          w_hi_nxt = w_prod_fix[2*WIDTH-1:WIDTH];
          w_lo_nxt = w_prod_fix[WIDTH-1:0];
        end else if (r_dbz) begin
          w_hi_nxt = r_a_raw;
          w_lo_nxt = '1;
        end else begin
          w_hi_nxt = w_r_fix;
          w_lo_nxt = w_q_fix;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_acc   <= w_acc_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_a_raw  <= '0;
      r_opnd   <= '0;
    end else if (w_load) begin
      r_is_div <= w_div_op;
      r_neg_lo <= w_sa ^ w_sb;
      r_neg_hi <= w_sa;
      r_dbz    <= w_div_op && (i_b == '0);
      r_a_raw  <= i_a;
      r_opnd   <= w_div_op ? w_b_mag : w_a_mag;
    end
  end

  assign o_mf_data = i_mf_sel ? r_hi : r_lo;
  assign o_stall   = i_mf_req & r_busy;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

endmodule
